// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide sequencer for the E stage: latches operands, counts fixed latency, commits HI/LO.
// Optional MADD/MADDU accumulate support is compiled in when MDU_MADD_EN is defined.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic        Req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        MDStall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, lo_q;
    logic        busy_q;

    function automatic logic is_long(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU:                  return 1'b1;
`endif
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
    endfunction

    function automatic logic [4:0] op_latency(input logic [3:0] op);
        if ((op == OP_DIV) || (op == OP_DIVU))
            return 5'(DIV_CYCLES);
        return 5'(MULT_CYCLES);
    endfunction

    // Datapath evaluated from the latched operands; only consumed at commit.
    logic        sgn;
    logic [63:0] a_ext, b_ext, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, den;
    logic [31:0] q_mag, r_mag, quot, rem;
    logic        div_zero;

    assign sgn   = is_signed_op(op_q);
    assign a_ext = {{32{sgn & a_q[31]}}, a_q};
    assign b_ext = {{32{sgn & b_q[31]}}, b_q};
    assign prod  = a_ext * b_ext;

    // Sign-magnitude division keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
    assign a_neg    = sgn & a_q[31];
    assign b_neg    = sgn & b_q[31];
    assign a_mag    = a_neg ? (32'd0 - a_q) : a_q;
    assign b_mag    = b_neg ? (32'd0 - b_q) : b_q;
    assign div_zero = (b_q == 32'd0);
    assign den      = div_zero ? 32'd1 : b_mag;
    assign q_mag    = a_mag / den;
    assign r_mag    = a_mag % den;
    assign quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem      = a_neg ? (32'd0 - r_mag) : r_mag;

`ifdef MDU_MADD_EN
    logic [63:0] acc;
    assign acc = {hi_q, lo_q} + prod;
`endif

    logic [31:0] hi_d, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        case (op_q)
            OP_MULT, OP_MULTU: begin
                hi_d = prod[63:32];
                lo_d = prod[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (!div_zero) begin
                    hi_d = rem;
                    lo_d = quot;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                hi_d = acc[63:32];
                lo_d = acc[31:0];
            end
`endif
            default: begin
                hi_d = hi_q;
                lo_d = lo_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start && !Req) begin
                        if (MDOp == OP_MTHI) begin
                            hi_q <= A;
                        end else if (MDOp == OP_MTLO) begin
                            lo_q <= A;
                        end else if (is_long(MDOp)) begin
                            op_q    <= MDOp;
                            a_q     <= A;
                            b_q     <= B;
                            cnt_q   <= op_latency(MDOp);
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Inputs, including Req, are ignored until the result commits.
                    if (cnt_q == 5'd1) begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        cnt_q   <= 5'd0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= 5'd0;
                end
            endcase
        end
    end

    assign Busy    = busy_q;
    assign MDStall = busy_q | (Start & ~Req & is_long(MDOp));
    assign HI      = hi_q;
    assign LO      = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: reference model pushes expected HI/LO/latency, popped when Busy falls.
module tb_md_unit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [3:0]  MDOp;
    logic        Req;
    logic [31:0] A, B;
    logic        Busy, MDStall;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    logic [31:0] exp_hi_q[$];
    logic [31:0] exp_lo_q[$];
    int          exp_cyc_q[$];

    always #5 clk = ~clk;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .Req(Req),
        .A(A), .B(B), .Busy(Busy), .MDStall(MDStall), .HI(HI), .LO(LO)
    );

    function automatic bit model_long(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op >= 4'd1 && op <= 4'd4) || op == 4'd7 || op == 4'd8;
`else
        return (op >= 4'd1 && op <= 4'd4);
`endif
    endfunction

    // Reference model: updates m_hi/m_lo and pushes expected commit values.
    task automatic model_push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int               ia, ib;
        longint           sa, sb, sp, q, r;
        longint unsigned  ua, ub, up;
        int               cyc;
        ia = a; ib = b; sa = ia; sb = ib;
        ua = a; ub = b;
        cyc = model_long(op) ? 5 : 0;
        case (op)
            4'd1: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
            4'd2: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
            4'd3: begin
                cyc = 10;
                if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
            end
            4'd4: begin
                cyc = 10;
                if (b != 0) begin up = ua / ub; m_lo = up[31:0]; up = ua % ub; m_hi = up[31:0]; end
            end
`ifdef MDU_MADD_EN
            4'd7: begin sp = sa * sb; up = {m_hi, m_lo} + sp; m_hi = up[63:32]; m_lo = up[31:0]; end
            4'd8: begin up = {m_hi, m_lo} + ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
`endif
            default: ;
        endcase
        exp_hi_q.push_back(m_hi);
        exp_lo_q.push_back(m_lo);
        exp_cyc_q.push_back(cyc);
    endtask

    task automatic idle_inputs();
        Start = 1'b0; Req = 1'b0; MDOp = 4'd0; A = 32'd0; B = 32'd0;
    endtask

    // Called at #1 after an edge; returns at #1 after the commit edge.
    task automatic issue_long(input string nm, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int req_cyc);
        logic [31:0] old_hi, old_lo, eh, el;
        int cyc, ec;
        bit exp_stall;
        old_hi = m_hi; old_lo = m_lo;
        exp_stall = model_long(op);
        model_push(op, a, b);
        Start = 1'b1; MDOp = op; A = a; B = b; Req = 1'b0;
        #1;
        n_checks++;
        if (MDStall !== exp_stall) begin
            n_fail++; $display("FAIL %s_stall: MDStall=%b required %b", nm, MDStall, exp_stall);
        end
        @(posedge clk); #1;
        idle_inputs();
        cyc = 0;
        while (Busy === 1'b1 && cyc < 40) begin
            cyc++;
            Req = (cyc == req_cyc);
            if (HI !== old_hi || LO !== old_lo) begin
                n_checks++; n_fail++;
                $display("FAIL %s_hold: HI=%h LO=%h required %h %h in busy cycle %0d", nm, HI, LO, old_hi, old_lo, cyc);
            end
            @(posedge clk); #1;
        end
        Req = 1'b0;
        eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front(); ec = exp_cyc_q.pop_front();
        n_checks++;
        if (cyc !== ec) begin
            n_fail++; $display("FAIL %s_latency: busy cycles=%0d required %0d", nm, cyc, ec);
        end
        n_checks++;
        if (HI !== eh || LO !== el) begin
            n_fail++; $display("FAIL %s_result: HI=%h LO=%h required HI=%h LO=%h", nm, HI, LO, eh, el);
        end
    endtask

    task automatic issue_single(input string nm, input logic [3:0] op, input logic [31:0] a, input logic req);
        Start = 1'b1; MDOp = op; A = a; B = 32'hDEAD_BEEF; Req = req;
        #1;
        n_checks++;
        if (MDStall !== 1'b0) begin
            n_fail++; $display("FAIL %s_stall: MDStall=%b required 0", nm, MDStall);
        end
        @(posedge clk); #1;
        idle_inputs();
        if (!req && op == 4'd5) m_hi = a;
        if (!req && op == 4'd6) m_lo = a;
        n_checks++;
        if (Busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
            n_fail++; $display("FAIL %s: Busy=%b HI=%h LO=%h required 0 %h %h", nm, Busy, HI, LO, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; idle_inputs();
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        m_hi = 0; m_lo = 0;
        n_checks++;
        if (Busy !== 1'b0 || MDStall !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++; $display("FAIL reset: Busy=%b MDStall=%b HI=%h LO=%h required 0 0 0 0", Busy, MDStall, HI, LO);
        end
    endtask

    task automatic test_mult();
        issue_long("mult_neg", 4'd1, 32'hFFFF_FFFE, 32'd3, 0);
        issue_long("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue_long("mult_mixed", 4'd1, 32'h8000_0000, 32'h7FFF_FFFF, 0);
    endtask

    task automatic test_div();
        issue_long("div_signed", 4'd3, 32'hFFFF_FFF9, 32'd2, 0);
        issue_long("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue_long("div_posneg", 4'd3, 32'd7, 32'hFFFF_FFFE, 0);
        issue_long("divu", 4'd4, 32'd7, 32'd2, 0);
        issue_long("divu_zero", 4'd4, 32'd5, 32'd0, 0);
        issue_long("div_zero", 4'd3, 32'hFFFF_0000, 32'd0, 0);
    endtask

    task automatic test_req();
        issue_single("req_mult", 4'd1, 32'h1111_1111, 1'b1);
        issue_single("req_mtlo", 4'd6, 32'h2222_2222, 1'b1);
        issue_long("mult_req_busy", 4'd1, 32'd1234, 32'd5678, 2);
    endtask

    task automatic test_mt();
        issue_single("mthi", 4'd5, 32'h1234_5678, 1'b0);
        issue_single("mtlo", 4'd6, 32'h9ABC_DEF0, 1'b0);
        issue_single("undef_op", 4'd12, 32'h5555_5555, 1'b0);
        issue_single("none_op", 4'd0, 32'h6666_6666, 1'b0);
    endtask

    task automatic test_reset_mid();
        int cyc;
        Start = 1'b1; MDOp = 4'd1; A = 32'd9; B = 32'd9;
        @(posedge clk); #1;
        idle_inputs();
        cyc = 1;
        while (cyc < 3) begin @(posedge clk); #1; cyc++; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = 0; m_lo = 0;
        n_checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid: Busy=%b HI=%h LO=%h required 0 0 0", Busy, HI, LO);
        end
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid_late: Busy=%b HI=%h LO=%h required 0 0 0", Busy, HI, LO);
        end
    endtask

    task automatic test_madd();
        issue_single("madd_sethi", 4'd5, 32'd0, 1'b0);
        issue_single("madd_setlo", 4'd6, 32'hFFFF_FFFF, 1'b0);
        issue_long("maddu", 4'd8, 32'd1, 32'd1, 0);
        issue_long("madd", 4'd7, 32'hFFFF_FFFF, 32'd2, 0);
    endtask

    task automatic test_back_to_back();
        issue_long("b2b_mult", 4'd1, 32'd100, 32'hFFFF_FFF6, 0);
        issue_long("b2b_divu", 4'd4, 32'hFFFF_FFFF, 32'd16, 0);
        issue_long("b2b_multu", 4'd2, 32'h0001_0000, 32'h0001_0000, 0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_mult();
        test_div();
        test_req();
        test_mt();
        test_reset_mid();
        test_madd();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the P7 pipeline, located in the E stage beside the ALU.
- Captures operands, selects signed or zero extension per opcode, and counts out the fixed latency. It then commits to the architectural HI/LO registers.
- Drives Busy and MDStall into the hazard unit, so that later MD instructions in D stall until the operation completes.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for MULT/MULTU (and MADD/MADDU); legal range 1..31.
- DIV_CYCLES, 10, cycles Busy stays high for DIV/DIVU; legal range 1..31.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- Start  input  1  E-stage instruction is an MD-class operation; sampled at the rising edge.
- MDOp  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU; 9-15 NONE.
- Req  input  1  exception/interrupt flush of the E-stage instruction; suppresses that cycle's Start.
- A  input  32  rs operand.
- B  input  32  rt operand.
- Busy  output  1  registered; high while an operation is in flight.
- MDStall  output  1  combinational: Busy | (Start & ~Req & MDOp in {1,2,3,4,7,8}).
- HI  output  32  registered architectural HI.
- LO  output  32  registered architectural LO.

Behaviour:
- Reset values: Busy=0, HI=0, LO=0, internal counter=0, operand/op latches=0. Reset mid-operation aborts it; HI/LO read 0 the next cycle.
- Accept condition:
  - Start & ~Req & ~Busy, sampled at edge t.
  - Start while Busy is ignored; the hazard unit guarantees it does not occur, and the bench must not rely on it.
  - Start with Req=1 is ignored entirely, including MTHI/MTLO.
- Long ops (MULT/MULTU/DIV/DIVU/MADD/MADDU):
  - At edge t, latch A, B and op, load counter with N (MULT_CYCLES or DIV_CYCLES), and set Busy=1.
  - Busy is high for cycles t+1..t+N.
  - At edge t+N, commit HI/LO and clear Busy. The new HI/LO and Busy=0 are visible in the same cycle.
  - HI/LO hold their old values while Busy.
  - Req during Busy does not cancel the operation; it is already committed architecturally.
- States:
  - IDLE -> RUN on accept of a long op.
  - RUN -> IDLE when the counter reaches 1 at an edge (commit).
  - RUN ignores all inputs.
- MTHI/MTLO (op 5/6):
  - Single cycle: HI<=A (resp. LO<=A) at edge t; Busy stays 0; the other register is unchanged.
- Arithmetic:
  - MULT: 64-bit product of sign-extended A, B; HI=prod[63:32], LO=prod[31:0].
  - MULTU: same with zero-extension.
  - DIV: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - DIVU: same on unsigned operands.
  - B=0 for DIV/DIVU: the op still takes DIV_CYCLES, and HI/LO are left unchanged at commit.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000 (no trap).
- Timing: results may be computed combinationally from the latched operands. They are written only at commit, never earlier.
- Ops 7/8 (MADD/MADDU) behave as NONE unless MDU_MADD_EN is defined.
- Undefined opcodes with Start=1 are accepted as NONE: no state change, and MDStall=0.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - MADD: {HI,LO} <= {HI,LO} + signed 64-bit product, at commit after MULT_CYCLES; the 64-bit sum wraps modulo 2^64.
  - MADDU: same with zero-extended operands.
  - The accumulate uses the HI/LO values present at commit.
- Undefined: opcodes 7/8 are treated as NONE (no Busy, no HI/LO change, MDStall=0).

Test Plan:
- Reset then MULT:
  - Stimulus: reset 2 cycles, then Start=1, MDOp=1, A=0xFFFFFFFE (-2), B=3 for one cycle.
  - Response: Busy high exactly 5 cycles; MDStall high in the Start cycle; HI=0xFFFFFFFF and LO=0xFFFFFFFA exactly when Busy falls.
- DIV signed:
  - Stimulus: MDOp=3, A=0xFFFFFFF9 (-7), B=2.
  - Response: Busy high 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU and divide-by-zero:
  - Stimulus: DIVU A=7, B=2, followed by DIVU A=5, B=0.
  - Response: the first gives LO=3, HI=1; the second keeps Busy 10 cycles and leaves HI=1, LO=3.
- Req suppression:
  - Stimulus: Start=1, MDOp=1, Req=1; separately MTLO with Req=1.
  - Response: Busy stays 0, MDStall=0, HI/LO unchanged.
  - Stimulus: MULT accepted, then Req pulsed in cycle 2 of Busy.
  - Response: commit still happens at cycle 5.
- MTHI/MTLO and reset mid-op:
  - Stimulus: MTHI A=0x12345678.
  - Response: HI=0x12345678 the next cycle with no Busy.
  - Stimulus: start MULT, assert reset at Busy cycle 3.
  - Response: next cycle Busy=0, HI=LO=0, and no late commit occurs.
- MDU_MADD_EN (build with and without):
  - Stimulus: HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1.
  - Response with macro: HI=1, LO=0 after 5 cycles.
  - Response without macro: no Busy and HI/LO unchanged.
